// File: rtl/axis_prefill_reader_pkg.sv
// Shared constants for the prefill reader: FSM encodings and underrun counter sizing.
package axis_prefill_reader_pkg;

  // Encoding 3 is never produced; the FSM falls back to StFill if it ever sees it.
  typedef enum logic [1:0] {
    StFill  = 2'd0,
    StRun   = 2'd1,
    StFlush = 2'd2
  } state_e;

  localparam int unsigned UnderrunWidth = 16;
  localparam logic [UnderrunWidth-1:0] UnderrunMax = '1;

  // Saturating increment for the underrun episode counter.
  function automatic logic [UnderrunWidth-1:0] sat_inc(input logic [UnderrunWidth-1:0] v);
    return (v == UnderrunMax) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Single-entry AXI-Stream output register with one-cycle latency and full throughput.
module axis_out_reg #(
  parameter int unsigned DataWidth = 32
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 enable,
  input  logic                 clear,
  input  logic [DataWidth-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [DataWidth-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [DataWidth-1:0] data_q, data_d;
  logic                 valid_q, valid_d;

  // Accept a new word when enabled and the slot is empty or being emptied this cycle.
  always_comb begin
    in_ready = enable & (~valid_q | out_ready);
  end

  // Next-state: clear discards the held word; otherwise load, drain, or hold.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (in_valid && in_ready) begin
      data_d  = in_data;
      valid_d = 1'b1;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Register update with synchronous active-low reset.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;

endmodule

// File: rtl/axis_prefill_reader.sv
// Holds off reading an external FIFO until it holds more than a threshold of words, then
// streams it out through a one-word register; tracks underrun episodes and supports flush.
module axis_prefill_reader
  import axis_prefill_reader_pkg::*;
#(
  parameter int unsigned AXIS_TDATA_WIDTH = 32,
  parameter int unsigned CNTR_WIDTH       = 32
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [CNTR_WIDTH-1:0]        cfg_data,
  input  logic                         cfg_rearm,
  input  logic                         cfg_flush,
  input  logic [CNTR_WIDTH-1:0]        axis_data_count,
  output logic                         s_axis_fifo_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0]  s_axis_fifo_tdata,
  input  logic                         s_axis_fifo_tvalid,
  input  logic                         m_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0]  m_axis_tdata,
  output logic                         m_axis_tvalid,
  output logic [1:0]                   sts_state,
  output logic [UnderrunWidth-1:0]     sts_underruns
);

  state_e                   state_q, state_d;
  logic                     run_en;
  logic                     reg_in_ready;
  logic                     starved;
  logic                     starved_q;
  logic                     episode;
  logic [UnderrunWidth-1:0] underruns_q, underruns_d;

  // Starvation is only meaningful while actively reading in RUN.
  assign starved = (state_q == StRun) & s_axis_fifo_tready & ~s_axis_fifo_tvalid;
  assign episode = starved & ~starved_q;

  // FSM state register.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= StFill;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: flush overrides threshold crossing and underrun rearm.
  always_comb begin
    state_d = state_q;
    if (cfg_flush) begin
      state_d = StFlush;
    end else begin
      case (state_q)
        StFill: begin
          if (axis_data_count > cfg_data) state_d = StRun;
        end
        StRun: begin
          if (episode && cfg_rearm) state_d = StFill;
        end
        StFlush: begin
          if (!s_axis_fifo_tvalid && (axis_data_count == '0)) state_d = StFill;
        end
        default: state_d = StFill;
      endcase
    end
  end

  // FSM outputs: FIFO ready is forced low during reset and in FILL; FLUSH drains freely.
  always_comb begin
    run_en             = 1'b0;
    s_axis_fifo_tready = 1'b0;
    if (aresetn) begin
      case (state_q)
        StRun: begin
          run_en             = 1'b1;
          s_axis_fifo_tready = reg_in_ready;
        end
        StFlush: s_axis_fifo_tready = 1'b1;
        default: s_axis_fifo_tready = 1'b0;
      endcase
    end
  end

  // Underrun counter next value: one count per rising edge of the starved condition.
  always_comb begin
    underruns_d = underruns_q;
    if (episode) underruns_d = sat_inc(underruns_q);
  end

  // Underrun counter and starved history.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      underruns_q <= '0;
      starved_q   <= 1'b0;
    end else begin
      underruns_q <= underruns_d;
      starved_q   <= starved;
    end
  end

  // Loading is gated to RUN; a word already held still drains after leaving RUN.
  axis_out_reg #(
    .DataWidth (AXIS_TDATA_WIDTH)
  ) u_out_reg (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .enable    (run_en),
    .clear     (cfg_flush),
    .in_data   (s_axis_fifo_tdata),
    .in_valid  (s_axis_fifo_tvalid),
    .in_ready  (reg_in_ready),
    .out_data  (m_axis_tdata),
    .out_valid (m_axis_tvalid),
    .out_ready (m_axis_tready)
  );

  assign sts_state     = state_q;
  assign sts_underruns = underruns_q;

endmodule

// File: tb/tb_axis_prefill_reader.sv
// Self-checking bench for axis_prefill_reader: threshold vector table plus directed sequences.
module tb_axis_prefill_reader;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 32;
  localparam logic [1:0] SFill  = 2'd0;
  localparam logic [1:0] SRun   = 2'd1;
  localparam logic [1:0] SFlush = 2'd2;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [CW-1:0] cfg_data;
  logic          cfg_rearm;
  logic          cfg_flush;
  logic [CW-1:0] axis_data_count;
  logic          s_axis_fifo_tready;
  logic [DW-1:0] s_axis_fifo_tdata;
  logic          s_axis_fifo_tvalid;
  logic          m_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic [1:0]    sts_state;
  logic [15:0]   sts_underruns;

  always #5 aclk = ~aclk;

  axis_prefill_reader #(
    .AXIS_TDATA_WIDTH (DW),
    .CNTR_WIDTH       (CW)
  ) dut (
    .aclk               (aclk),
    .aresetn            (aresetn),
    .cfg_data           (cfg_data),
    .cfg_rearm          (cfg_rearm),
    .cfg_flush          (cfg_flush),
    .axis_data_count    (axis_data_count),
    .s_axis_fifo_tready (s_axis_fifo_tready),
    .s_axis_fifo_tdata  (s_axis_fifo_tdata),
    .s_axis_fifo_tvalid (s_axis_fifo_tvalid),
    .m_axis_tready      (m_axis_tready),
    .m_axis_tdata       (m_axis_tdata),
    .m_axis_tvalid      (m_axis_tvalid),
    .sts_state          (sts_state),
    .sts_underruns      (sts_underruns)
  );

  // FIFO model and output scoreboard
  logic [DW-1:0] fifo[$];
  logic [DW-1:0] out_q[$];
  bit            gate;
  bit            use_fifo_count;
  logic [CW-1:0] manual_count;
  bit            last_fire_s;
  int            hold_viol;
  int            checks;
  int            failures;

  typedef struct {
    logic [CW-1:0] thr;
    logic [CW-1:0] cnt;
    logic [1:0]    exp_state;
  } vec_t;
  vec_t vecs[8];

  function automatic logic [DW-1:0] wd(input int t, input int k);
    return DW'((t << 24) | k);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive();
    s_axis_fifo_tvalid = gate && (fifo.size() != 0);
    s_axis_fifo_tdata  = (fifo.size() != 0) ? fifo[0] : '0;
    axis_data_count    = use_fifo_count ? CW'(fifo.size()) : manual_count;
  endtask

  // Called at a negedge; spans exactly one rising edge and returns at the next negedge.
  task automatic cycle();
    drive();
    #1;
    if (m_axis_tvalid && !m_axis_tready && s_axis_fifo_tready) hold_viol++;
    last_fire_s = s_axis_fifo_tready && s_axis_fifo_tvalid;
    if (m_axis_tvalid && m_axis_tready) out_q.push_back(m_axis_tdata);
    if (last_fire_s) void'(fifo.pop_front());
    @(negedge aclk);
  endtask

  task automatic do_reset();
    fifo.delete();
    out_q.delete();
    gate           = 1'b1;
    use_fifo_count = 1'b1;
    cfg_flush      = 1'b0;
    aresetn        = 1'b0;
    cycle();
    cycle();
    aresetn = 1'b1;
  endtask

  function automatic logic [DW-1:0] out_at(input int i);
    return (i < out_q.size()) ? out_q[i] : 'x;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int  n_out;
    bit  seen_run;
    int  fires;

    checks = 0; failures = 0; hold_viol = 0;
    aresetn = 1'b0; cfg_data = '0; cfg_rearm = 1'b0; cfg_flush = 1'b0;
    m_axis_tready = 1'b0; manual_count = '0; gate = 1'b1; use_fifo_count = 1'b1;
    drive();
    @(negedge aclk);

    // Threshold vectors: strict unsigned compare, including the never-exit threshold.
    vecs[0] = '{thr: 32'd4,          cnt: 32'd4,          exp_state: SFill};
    vecs[1] = '{thr: 32'd4,          cnt: 32'd5,          exp_state: SRun};
    vecs[2] = '{thr: 32'd0,          cnt: 32'd0,          exp_state: SFill};
    vecs[3] = '{thr: 32'd0,          cnt: 32'd1,          exp_state: SRun};
    vecs[4] = '{thr: 32'hFFFF_FFFF,  cnt: 32'hFFFF_FFFF,  exp_state: SFill};
    vecs[5] = '{thr: 32'hFFFF_FFFE,  cnt: 32'hFFFF_FFFF,  exp_state: SRun};
    vecs[6] = '{thr: 32'h8000_0000,  cnt: 32'h7FFF_FFFF,  exp_state: SFill};
    vecs[7] = '{thr: 32'h7FFF_FFFF,  cnt: 32'h8000_0000,  exp_state: SRun};
    for (int v = 0; v < 8; v++) begin
      m_axis_tready = 1'b1;
      do_reset();
      check($sformatf("vec%0d_reset_state", v), sts_state, SFill);
      check($sformatf("vec%0d_reset_tvalid", v), m_axis_tvalid, 1'b0);
      cfg_data       = vecs[v].thr;
      use_fifo_count = 1'b0;
      manual_count   = vecs[v].cnt;
      cycle();
      cycle();
      check($sformatf("vec%0d_state", v), sts_state, vecs[v].exp_state);
      check($sformatf("vec%0d_fifo_tready", v), s_axis_fifo_tready,
            (vecs[v].exp_state == SRun) ? 1'b1 : 1'b0);
    end
    use_fifo_count = 1'b1;

    // Fill ramp 0..6 with threshold 4, then first-word latency and streaming.
    do_reset();
    cfg_data = 32'd4; cfg_rearm = 1'b0; m_axis_tready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cycle();
      check($sformatf("ramp_state_after_cnt%0d", k), sts_state, (k >= 5) ? SRun : SFill);
      fifo.push_back(wd(2, k));
    end
    check("ramp_tvalid_before_read", m_axis_tvalid, 1'b0);
    cycle();
    check("ramp_first_read", last_fire_s, 1'b1);
    check("ramp_first_tvalid", m_axis_tvalid, 1'b1);
    check("ramp_first_tdata", m_axis_tdata, wd(2, 0));
    fires = 0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      if (last_fire_s) fires++;
    end
    cycle();
    check("ramp_throughput_reads", fires, 5);
    check("ramp_out_count", out_q.size(), 6);
    for (int i = 0; i < 6; i++) check($sformatf("ramp_out%0d", i), out_at(i), wd(2, i));

    // Backpressure: ready toggles every cycle, 16 words must arrive in order.
    do_reset();
    cfg_data = 32'd0; cfg_rearm = 1'b0;
    for (int i = 0; i < 16; i++) fifo.push_back(wd(3, i));
    hold_viol = 0;
    for (int c = 0; c < 100 && out_q.size() < 16; c++) begin
      m_axis_tready = c[0];
      cycle();
    end
    check("bp_out_count", out_q.size(), 16);
    for (int i = 0; i < 16; i++) check($sformatf("bp_out%0d", i), out_at(i), wd(3, i));
    check("bp_ready_while_full", hold_viol, 0);

    // Rearm: underrun returns to FILL, refill past threshold returns to RUN.
    do_reset();
    cfg_rearm = 1'b1; cfg_data = 32'd4; m_axis_tready = 1'b1;
    for (int i = 0; i < 5; i++) fifo.push_back(wd(4, i));
    seen_run = 1'b0;
    for (int c = 0; c < 20; c++) begin
      cycle();
      if (sts_state == SRun) seen_run = 1'b1;
      else if (seen_run && sts_state == SFill) break;
    end
    check("rearm_seen_run", seen_run, 1'b1);
    check("rearm_state_fill", sts_state, SFill);
    check("rearm_underruns", sts_underruns, 16'd1);
    check("rearm_out_count", out_q.size(), 5);
    check("rearm_last_word", out_at(4), wd(4, 4));
    for (int k = 0; k < 6; k++) begin
      cycle();
      if (k == 4) check("refill_cnt4_fill", sts_state, SFill);
      if (k == 5) check("refill_cnt5_run", sts_state, SRun);
      fifo.push_back(wd(4, 10 + k));
    end
    check("refill_underruns", sts_underruns, 16'd1);

    // No rearm: three gaps counted, stay in RUN; then saturation at 0xFFFF.
    do_reset();
    cfg_rearm = 1'b0; cfg_data = 32'd0; m_axis_tready = 1'b1;
    for (int g = 0; g < 3; g++) begin
      fifo.push_back(wd(5, 2 * g));
      fifo.push_back(wd(5, 2 * g + 1));
      repeat (4) cycle();
    end
    check("norearm_underruns", sts_underruns, 16'd3);
    check("norearm_state", sts_state, SRun);
    check("norearm_out_count", out_q.size(), 6);
    check("norearm_last_word", out_at(5), wd(5, 5));
    force dut.underruns_q = 16'hFFFE;
    cycle();
    release dut.underruns_q;
    check("sat_preload", sts_underruns, 16'hFFFE);
    fifo.push_back(wd(5, 6));
    repeat (3) cycle();
    check("sat_first_gap", sts_underruns, 16'hFFFF);
    fifo.push_back(wd(5, 7));
    repeat (3) cycle();
    check("sat_second_gap", sts_underruns, 16'hFFFF);
    check("sat_state", sts_state, SRun);

    // Flush in RUN with a held word and 8 words queued.
    do_reset();
    cfg_data = 32'd0; cfg_rearm = 1'b0; m_axis_tready = 1'b0;
    fifo.push_back(wd(6, 0));
    cycle();
    cycle();
    check("flush_pre_tvalid", m_axis_tvalid, 1'b1);
    for (int i = 1; i <= 8; i++) fifo.push_back(wd(6, i));
    cfg_flush = 1'b1;
    cycle();
    cfg_flush = 1'b0;
    check("flush_state", sts_state, SFlush);
    check("flush_tvalid_cleared", m_axis_tvalid, 1'b0);
    m_axis_tready = 1'b1;
    n_out = out_q.size();
    repeat (8) cycle();
    check("flush_fifo_drained", fifo.size(), 0);
    check("flush_still_flush", sts_state, SFlush);
    check("flush_no_output", out_q.size(), n_out);
    #1;
    check("flush_tready", s_axis_fifo_tready, 1'b1);
    cycle();
    check("flush_exit_fill", sts_state, SFill);

    // Reset pulse mid-RUN with a held word and a nonzero underrun count.
    do_reset();
    cfg_data = 32'd0; cfg_rearm = 1'b0; m_axis_tready = 1'b1;
    fifo.push_back(wd(7, 0));
    repeat (3) cycle();
    m_axis_tready = 1'b0;
    fifo.push_back(wd(7, 1));
    cycle();
    check("rst_pre_underruns", sts_underruns, 16'd1);
    check("rst_pre_tvalid", m_axis_tvalid, 1'b1);
    aresetn = 1'b0;
    #1;
    check("rst_tready_low", s_axis_fifo_tready, 1'b0);
    cycle();
    aresetn = 1'b1;
    check("rst_tvalid", m_axis_tvalid, 1'b0);
    check("rst_state", sts_state, SFill);
    check("rst_underruns", sts_underruns, 16'd0);
    check("rst_tdata", m_axis_tdata, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_prefill_reader.md
AXIS_PREFILL_READER -- requirements
Module: axis_prefill_reader

Interface
REQ-001 Parameter AXIS_TDATA_WIDTH, default 32: stream data width in bits.
REQ-002 Parameter CNTR_WIDTH, default 32: width of the threshold and FIFO fill count.
REQ-003 aclk  input  1  clock; all logic is clocked on the rising edge.
REQ-004 aresetn  input  1  reset, synchronous, active-low.
REQ-005 cfg_data  input  CNTR_WIDTH  prefill threshold in words.
REQ-006 cfg_rearm  input  1  1 = return to FILL after an underrun; 0 = stay in RUN permanently.
REQ-007 cfg_flush  input  1  flush request, sampled every cycle.
REQ-008 axis_data_count  input  CNTR_WIDTH  fill count of the external FIFO.
REQ-009 s_axis_fifo_tready  output  1; s_axis_fifo_tdata  input  AXIS_TDATA_WIDTH; s_axis_fifo_tvalid  input  1: read side of the FIFO.
REQ-010 m_axis_tready  input  1; m_axis_tdata  output  AXIS_TDATA_WIDTH; m_axis_tvalid  output  1: output stream.
REQ-011 sts_state  output  2  current state: 0=FILL, 1=RUN, 2=FLUSH.
REQ-012 sts_underruns  output  16  saturating count of underrun episodes.

Function
REQ-013 The FSM SHALL have three states, FILL, RUN and FLUSH, and SHALL never take encoding 3.
REQ-014 FILL: s_axis_fifo_tready=0; the block SHALL go to RUN on the first cycle with axis_data_count > cfg_data (strict comparison, unsigned).
REQ-015 RUN: the block SHALL move words from the FIFO into a single output register, m_axis_tdata/m_axis_tvalid.
REQ-016 In RUN, s_axis_fifo_tready SHALL be (~m_axis_tvalid | m_axis_tready).
REQ-017 Latency SHALL be 1 cycle: a FIFO word accepted in cycle N appears on m_axis in cycle N+1.
REQ-018 The output register SHALL hold its value while m_axis_tvalid=1 and m_axis_tready=0.
REQ-019 The block SHALL sustain full throughput (1 word/cycle) while the FIFO is non-empty and m_axis_tready=1.
REQ-020 Starved condition: state RUN, s_axis_fifo_tready=1 and s_axis_fifo_tvalid=0.
REQ-021 An underrun episode is a cycle where the starved condition is true and was false in the previous cycle.
REQ-022 sts_underruns SHALL increment by 1 per underrun episode and saturate at 0xFFFF.
REQ-023 On an underrun episode with cfg_rearm=1, the FSM SHALL go to FILL.
REQ-024 The word already in the output register SHALL still be delivered normally after that transition to FILL.
REQ-025 With cfg_rearm=0, the FSM SHALL remain in RUN and resume as soon as s_axis_fifo_tvalid returns.
REQ-026 cfg_flush=1 in any state SHALL force FLUSH on the next cycle and SHALL clear m_axis_tvalid on the next cycle, discarding the held word.
REQ-027 cfg_flush SHALL take priority over a threshold crossing or underrun in the same cycle.
REQ-028 FLUSH: s_axis_fifo_tready=1; every word is discarded; m_axis_tvalid=0.
REQ-029 The FSM SHALL leave FLUSH for FILL when cfg_flush=0, s_axis_fifo_tvalid=0 and axis_data_count=0.
REQ-030 Changes to cfg_data SHALL only affect the FILL state evaluation; changes to cfg_rearm take effect immediately.
REQ-031 With cfg_data >= 2^CNTR_WIDTH-1, FILL SHALL never exit; this is not an error.

Reset
REQ-032 On aresetn=0 the block SHALL set: state FILL, m_axis_tvalid=0, m_axis_tdata=0, sts_underruns=0, and the starved history flag=0.
REQ-033 s_axis_fifo_tready SHALL be 0 while aresetn=0.
REQ-034 A reset asserted mid-RUN SHALL drop m_axis_tvalid in the cycle after the reset is sampled; the held word is lost.

Structure
REQ-035 State encodings (FILL/RUN/FLUSH) and the underrun counter width SHALL be defined as constants in a shared package.
REQ-036 The output register SHALL be a sub-module, axis_out_reg, with handshake per REQ-016 to REQ-018; the FSM and counter SHALL live in the top.

Verification
REQ-037 cfg_data=4; fill count ramps 0..6 -> RUN entered the cycle after count=5; first m_axis word appears 1 cycle after the first FIFO read.
REQ-038 RUN, m_axis_tready toggled 1/0 every cycle, 16 words -> all 16 words are delivered in order with no duplicates or drops; s_axis_fifo_tready=0 whenever the register is full and not ready.
REQ-039 cfg_rearm=1; FIFO empties mid-stream -> sts_underruns=1 and state FILL; refill to count 5 with cfg_data=4 -> RUN again.
REQ-040 cfg_rearm=0; 3 separate starvation gaps -> sts_underruns=3 and state stays RUN; preload counter near 0xFFFF and force 2 more gaps -> count holds at 0xFFFF.
REQ-041 cfg_flush pulsed in RUN with 8 words in the FIFO -> m_axis_tvalid=0 next cycle; all 8 words are drained with no output; state returns to FILL when count=0.
REQ-042 aresetn low for 1 cycle while m_axis_tvalid=1 -> next cycle m_axis_tvalid=0, sts_state=0, sts_underruns=0.
